// File: rtl/mp4_types.sv
// Shared mp4 types: cache-line geometry and the physical-memory arbiter state encoding.
package mp4_types;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int BEATS      = LINE_W / BURST_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int BURST_SH   = $clog2(BURST_W);
  localparam int LINE_IDX_W = $clog2(LINE_W);

  localparam logic [ADDR_W-1:0] LINE_ADDR_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Moves one cache line as BEATS little-endian bursts: owns the beat counter and line buffer.
// start loads the buffer (writeback data) and rewinds the counter; done flags the last accepted beat.
module cacheline_adaptor
  import mp4_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LINE_W-1:0]   start_line,
  input  logic                active,
  input  logic                is_read,
  input  logic                mem_resp,
  input  logic [BURST_W-1:0]  mem_rdata,
  output logic [BURST_W-1:0]  mem_wdata,
  output logic                done,
  output logic [LINE_W-1:0]   line_next
);

  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [LINE_IDX_W-1:0] beat_base;

  assign beat_base = {beat_q, {BURST_SH{1'b0}}};

  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    done   = 1'b0;
    if (start) begin
      beat_d = '0;
      line_d = start_line;
    end else if (active && mem_resp) begin
      if (is_read) begin
        line_d[beat_base +: BURST_W] = mem_rdata;
      end
      // The counter is exactly BEAT_IDX_W bits wide, so the last beat wraps it to 0.
      beat_d = beat_q + 1'b1;
      done   = (beat_q == BEAT_IDX_W'(BEATS - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
    end
  end

  assign mem_wdata = line_q[beat_base +: BURST_W];
  assign line_next = line_d;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache/dcache line fills and dcache writebacks onto the single burst pmem port.
// Optional macro PMEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed dcache priority.
module pmem_arbiter
  import mp4_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                icache_pmem_read,
  input  logic [ADDR_W-1:0]   icache_pmem_address,
  output logic [LINE_W-1:0]   icache_pmem_rdata,
  output logic                icache_pmem_resp,
  input  logic                dcache_pmem_read,
  input  logic                dcache_pmem_write,
  input  logic [ADDR_W-1:0]   dcache_pmem_address,
  input  logic [LINE_W-1:0]   dcache_pmem_wdata,
  output logic [LINE_W-1:0]   dcache_pmem_rdata,
  output logic                dcache_pmem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [BURST_W-1:0]  pmem_wdata,
  input  logic [BURST_W-1:0]  pmem_rdata,
  input  logic                pmem_resp
);

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                owner_q, owner_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                start;
  logic                done;
  logic [LINE_W-1:0]   line_next;
  logic                dcache_req;
  logic                pick_icache;

  assign dcache_req = dcache_pmem_read || dcache_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // last_grant: 0 = icache, 1 = dcache; on contention the side not granted last wins.
  assign pick_icache = icache_pmem_read && (!dcache_req || last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (start) begin
      last_grant_d = !pick_icache;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_icache = icache_pmem_read && !dcache_req;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    owner_d   = owner_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_icache) begin
          state_d = I_READ;
          addr_d  = icache_pmem_address & LINE_ADDR_MASK;
          owner_d = 1'b0;
          start   = 1'b1;
        end else if (dcache_req) begin
          state_d = dcache_pmem_write ? D_WRITE : D_READ;
          addr_d  = dcache_pmem_address & LINE_ADDR_MASK;
          owner_d = 1'b1;
          start   = 1'b1;
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (done) begin
          state_d = DONE;
          // Capture the finished line so it is stable while the cache sees resp.
          if (state_q == I_READ) begin
            i_rdata_d = line_next;
          end else if (state_q == D_READ) begin
            d_rdata_d = line_next;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      owner_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      owner_q   <= owner_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  cacheline_adaptor u_adaptor (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_line (dcache_pmem_wdata),
    .active     (pmem_read || pmem_write),
    .is_read    (pmem_read),
    .mem_resp   (pmem_resp),
    .mem_rdata  (pmem_rdata),
    .mem_wdata  (pmem_wdata),
    .done       (done),
    .line_next  (line_next)
  );

  assign pmem_read         = (state_q == I_READ) || (state_q == D_READ);
  assign pmem_write        = (state_q == D_WRITE);
  assign pmem_address      = addr_q;
  assign icache_pmem_resp  = (state_q == DONE) && !owner_q;
  assign dcache_pmem_resp  = (state_q == DONE) && owner_q;
  assign icache_pmem_rdata = i_rdata_q;
  assign dcache_pmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a burst memory responder plus a transaction-level grant/line model.
// Builds with or without PMEM_ARB_ROUND_ROBIN_EN; the grant model follows the same macro.
module tb_pmem_arbiter;
  import mp4_types::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                icache_pmem_read;
  logic [ADDR_W-1:0]   icache_pmem_address;
  logic [LINE_W-1:0]   icache_pmem_rdata;
  logic                icache_pmem_resp;
  logic                dcache_pmem_read;
  logic                dcache_pmem_write;
  logic [ADDR_W-1:0]   dcache_pmem_address;
  logic [LINE_W-1:0]   dcache_pmem_wdata;
  logic [LINE_W-1:0]   dcache_pmem_rdata;
  logic                dcache_pmem_resp;
  logic                pmem_read;
  logic                pmem_write;
  logic [ADDR_W-1:0]   pmem_address;
  logic [BURST_W-1:0]  pmem_wdata;
  logic [BURST_W-1:0]  pmem_rdata;
  logic                pmem_resp;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: who was granted most recently, and the line each cache should currently see.
  logic        model_last_d;
  logic [LINE_W-1:0] exp_i_rdata;
  logic [LINE_W-1:0] exp_d_rdata;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Grant rules: 0 = icache read, 1 = dcache read, 2 = dcache write, -1 = nobody asking.
  function automatic int predict_grant(input logic ir, input logic dr, input logic dw, input logic last_d);
    logic d_wants;
    d_wants = dr || dw;
    if (!ir && !d_wants) return -1;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    if (ir && (!d_wants || last_d)) return 0;
`else
    if (!d_wants) return 0;
`endif
    return dw ? 2 : 1;
  endfunction

  // Memory side: waits (bounded) for a burst, then accepts BEATS beats with `gap` idle cycles before each.
  // Returns at the negedge of the cycle after the last accepted beat.
  task automatic serve_burst(input int gap, input logic [LINE_W-1:0] rline,
                             output int latency, output logic [ADDR_W-1:0] addr,
                             output logic saw_read, output logic saw_write,
                             output logic [LINE_W-1:0] wline, output int hold_err,
                             output int early_resp);
    latency = 0; hold_err = 0; early_resp = 0;
    addr = '0; saw_read = 1'b0; saw_write = 1'b0; wline = '0;
    while (!(pmem_read || pmem_write) && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    if (!(pmem_read || pmem_write)) return;
    addr = pmem_address; saw_read = pmem_read; saw_write = pmem_write;
    for (int b = 0; b < BEATS; b++) begin
      for (int g = 0; g < gap; g++) begin
        pmem_resp = 1'b0;
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        if (pmem_read !== saw_read || pmem_write !== saw_write) hold_err++;
        if (icache_pmem_resp || dcache_pmem_resp) early_resp++;
      end
      pmem_resp = 1'b1;
      pmem_rdata = rline[b*BURST_W +: BURST_W];
      wline[b*BURST_W +: BURST_W] = pmem_wdata;
      @(negedge clk);
      if (b < BEATS - 1) begin
        if (pmem_read !== saw_read || pmem_write !== saw_write) hold_err++;
        if (icache_pmem_resp || dcache_pmem_resp) early_resp++;
      end
    end
    pmem_resp = 1'b0;
    pmem_rdata = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (pmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pmem_read: got %b want 0", pmem_read); end
    vectors++; if (pmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pmem_write: got %b want 0", pmem_write); end
    vectors++; if (pmem_address !== '0) begin miscompares++; $display("[TB] FAIL rst_pmem_address: got %h want 0", pmem_address); end
    vectors++; if (pmem_wdata !== '0) begin miscompares++; $display("[TB] FAIL rst_pmem_wdata: got %h want 0", pmem_wdata); end
    vectors++; if (icache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_i_resp: got %b want 0", icache_pmem_resp); end
    vectors++; if (dcache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_d_resp: got %b want 0", dcache_pmem_resp); end
    vectors++; if (icache_pmem_rdata !== '0) begin miscompares++; $display("[TB] FAIL rst_i_rdata: got %h want 0", icache_pmem_rdata); end
    vectors++; if (dcache_pmem_rdata !== '0) begin miscompares++; $display("[TB] FAIL rst_d_rdata: got %h want 0", dcache_pmem_rdata); end
    rst = 1'b0;
    model_last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_icache_read();
    logic [LINE_W-1:0] rl, wl; int lat, he, er; logic [ADDR_W-1:0] a; logic sr, sw;
    rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    icache_pmem_address = 32'h0000_0060; icache_pmem_read = 1'b1;
    serve_burst(0, rl, lat, a, sr, sw, wl, he, er);
    model_last_d = 1'b0; exp_i_rdata = rl;
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL ird_latency: got %0d want 1", lat); end
    vectors++; if (a !== 32'h0000_0060) begin miscompares++; $display("[TB] FAIL ird_addr: got %h want 00000060", a); end
    vectors++; if (sr !== 1'b1 || sw !== 1'b0) begin miscompares++; $display("[TB] FAIL ird_kind: got r%b w%b want r1 w0", sr, sw); end
    vectors++; if (he !== 0 || er !== 0) begin miscompares++; $display("[TB] FAIL ird_hold: got hold_err %0d early_resp %0d want 0 0", he, er); end
    vectors++; if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL ird_resp: got i%b d%b want i1 d0", icache_pmem_resp, dcache_pmem_resp); end
    vectors++; if (icache_pmem_rdata !== exp_i_rdata) begin miscompares++; $display("[TB] FAIL ird_rdata: got %h want %h", icache_pmem_rdata, exp_i_rdata); end
    vectors++; if (pmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL ird_drop: got pmem_read %b want 0", pmem_read); end
    icache_pmem_read = 1'b0;
    @(negedge clk);
    vectors++; if (icache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL ird_pulse: got %b want 0", icache_pmem_resp); end
    vectors++; if (dcache_pmem_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL ird_d_hold: got %h want %h", dcache_pmem_rdata, exp_d_rdata); end
  endtask

  task automatic test_dcache_write();
    logic [LINE_W-1:0] wd, wl; int lat, he, er; logic [ADDR_W-1:0] a; logic sr, sw;
    wd = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    dcache_pmem_address = 32'h0000_1004; dcache_pmem_wdata = wd; dcache_pmem_write = 1'b1;
    serve_burst(0, rand_line(), lat, a, sr, sw, wl, he, er);
    model_last_d = 1'b1;
    vectors++; if (a !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL dwr_addr: got %h want 00001000", a); end
    vectors++; if (sw !== 1'b1 || sr !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_kind: got r%b w%b want r0 w1", sr, sw); end
    vectors++; if (wl !== wd) begin miscompares++; $display("[TB] FAIL dwr_beats: got %h want %h", wl, wd); end
    vectors++; if (lat !== 1 || he !== 0) begin miscompares++; $display("[TB] FAIL dwr_timing: got lat %0d hold_err %0d want 1 0", lat, he); end
    vectors++; if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_resp: got i%b d%b want i0 d1", icache_pmem_resp, dcache_pmem_resp); end
    vectors++; if (icache_pmem_rdata !== exp_i_rdata || dcache_pmem_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL dwr_rdata_hold: got i %h d %h", icache_pmem_rdata, dcache_pmem_rdata); end
    dcache_pmem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [LINE_W-1:0] l1, l2, wl; int lat, he, er, g; logic [ADDR_W-1:0] a, want_a; logic sr, sw;
    icache_pmem_address = 32'h0000_0200; dcache_pmem_address = 32'h0000_3000;
    icache_pmem_read = 1'b1; dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b0;
    for (int t = 0; t < 2; t++) begin
      g = predict_grant(icache_pmem_read, dcache_pmem_read, 1'b0, model_last_d);
      model_last_d = (g != 0);
      l1 = rand_line();
      serve_burst(0, l1, lat, a, sr, sw, wl, he, er);
      if (g == 0) exp_i_rdata = l1; else exp_d_rdata = l1;
      want_a = (g == 0) ? 32'h0000_0200 : 32'h0000_3000;
      vectors++; if (a !== want_a) begin miscompares++; $display("[TB] FAIL sim%0d_addr: got %h want %h", t, a, want_a); end
      vectors++; if (lat !== t + 1) begin miscompares++; $display("[TB] FAIL sim%0d_latency: got %0d want %0d", t, lat, t + 1); end
      vectors++; if (icache_pmem_resp !== (g == 0) || dcache_pmem_resp !== (g != 0)) begin miscompares++; $display("[TB] FAIL sim%0d_resp: got i%b d%b grant %0d", t, icache_pmem_resp, dcache_pmem_resp, g); end
      vectors++; if (icache_pmem_rdata !== exp_i_rdata || dcache_pmem_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL sim%0d_rdata: got i %h d %h", t, icache_pmem_rdata, dcache_pmem_rdata); end
      if (g == 0) icache_pmem_read = 1'b0; else dcache_pmem_read = 1'b0;
    end
    l2 = '0;
    @(negedge clk);
    vectors++; if (pmem_read !== 1'b0 || icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_quiet: got rd%b i%b d%b want 0 0 0%h", pmem_read, icache_pmem_resp, dcache_pmem_resp, l2[0]); end
  endtask

  task automatic test_read_write_together();
    logic [LINE_W-1:0] wd, wl; int lat, he, er; logic [ADDR_W-1:0] a; logic sr, sw;
    wd = rand_line();
    dcache_pmem_address = 32'h4444_4448; dcache_pmem_wdata = wd;
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1;
    serve_burst(0, rand_line(), lat, a, sr, sw, wl, he, er);
    model_last_d = 1'b1;
    vectors++; if (sw !== 1'b1 || sr !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_kind: got r%b w%b want r0 w1", sr, sw); end
    vectors++; if (a !== 32'h4444_4440) begin miscompares++; $display("[TB] FAIL rw_addr: got %h want 44444440", a); end
    vectors++; if (wl !== wd) begin miscompares++; $display("[TB] FAIL rw_beats: got %h want %h", wl, wd); end
    vectors++; if (dcache_pmem_resp !== 1'b1 || dcache_pmem_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL rw_resp: got resp %b rdata %h want 1 %h", dcache_pmem_resp, dcache_pmem_rdata, exp_d_rdata); end
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic [LINE_W-1:0] rl, wl; int lat, he, er, n; logic [ADDR_W-1:0] a; logic sr, sw;
    icache_pmem_address = 32'h0000_0080; icache_pmem_read = 1'b1;
    n = 0;
    while (!pmem_read && n < 20) begin @(negedge clk); n++; end
    vectors++; if (pmem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL mrst_start: got pmem_read %b want 1", pmem_read); end
    pmem_resp = 1'b1; pmem_rdata = 64'hBAD0_BAD0_BAD0_0000;
    @(negedge clk);
    pmem_rdata = 64'hBAD0_BAD0_BAD0_0001;
    @(negedge clk);
    pmem_resp = 1'b0;
    rst = 1'b1;
    #1;
    vectors++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL mrst_cmd: got r%b w%b want 0 0", pmem_read, pmem_write); end
    vectors++; if (pmem_address !== '0 || pmem_wdata !== '0) begin miscompares++; $display("[TB] FAIL mrst_bus: got addr %h wdata %h want 0 0", pmem_address, pmem_wdata); end
    vectors++; if (icache_pmem_rdata !== '0 || dcache_pmem_rdata !== '0) begin miscompares++; $display("[TB] FAIL mrst_rdata: got i %h d %h want 0 0", icache_pmem_rdata, dcache_pmem_rdata); end
    @(negedge clk);
    vectors++; if (icache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL mrst_noresp: got %b want 0", icache_pmem_resp); end
    rst = 1'b0;
    model_last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    rl = rand_line();
    serve_burst(0, rl, lat, a, sr, sw, wl, he, er);
    exp_i_rdata = rl;
    vectors++; if (lat !== 1 || a !== 32'h0000_0080) begin miscompares++; $display("[TB] FAIL mrst_restart: got lat %0d addr %h want 1 00000080", lat, a); end
    vectors++; if (icache_pmem_resp !== 1'b1 || icache_pmem_rdata !== exp_i_rdata) begin miscompares++; $display("[TB] FAIL mrst_line: got resp %b rdata %h want 1 %h", icache_pmem_resp, icache_pmem_rdata, exp_i_rdata); end
    icache_pmem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slow_memory();
    logic [LINE_W-1:0] rl, wl; int lat, he, er; logic [ADDR_W-1:0] a; logic sr, sw;
    rl = rand_line();
    dcache_pmem_address = 32'h0000_5010; dcache_pmem_read = 1'b1;
    serve_burst(3, rl, lat, a, sr, sw, wl, he, er);
    model_last_d = 1'b1; exp_d_rdata = rl;
    vectors++; if (he !== 0) begin miscompares++; $display("[TB] FAIL slow_hold: got %0d dropouts want 0", he); end
    vectors++; if (er !== 0) begin miscompares++; $display("[TB] FAIL slow_early: got %0d early resp want 0", er); end
    vectors++; if (dcache_pmem_resp !== 1'b1 || dcache_pmem_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL slow_line: got resp %b rdata %h want 1 %h", dcache_pmem_resp, dcache_pmem_rdata, exp_d_rdata); end
    vectors++; if (a !== 32'h0000_5000) begin miscompares++; $display("[TB] FAIL slow_addr: got %h want 00005000", a); end
    dcache_pmem_read = 1'b0;
    @(negedge clk);
    vectors++; if (dcache_pmem_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL slow_pulse: got %b want 0", dcache_pmem_resp); end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] rl, wd, wl; int lat, he, er, g, gap; logic [ADDR_W-1:0] a, want_a; logic sr, sw;
    logic ir, dr, dw;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
      end
      do begin
        ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
      end while (!(ir || dr || dw));
      icache_pmem_address = $urandom; dcache_pmem_address = $urandom;
      wd = rand_line(); rl = rand_line(); gap = $urandom_range(0, 2);
      dcache_pmem_wdata = wd;
      icache_pmem_read = ir; dcache_pmem_read = dr; dcache_pmem_write = dw;
      g = predict_grant(ir, dr, dw, model_last_d);
      model_last_d = (g != 0);
      want_a = ((g == 0) ? icache_pmem_address : dcache_pmem_address) & 32'hFFFF_FFE0;
      serve_burst(gap, rl, lat, a, sr, sw, wl, he, er);
      if (g == 0) exp_i_rdata = rl;
      if (g == 1) exp_d_rdata = rl;
      vectors++; if (lat !== 1 || a !== want_a) begin miscompares++; $display("[TB] FAIL b2b%0d_grant: got lat %0d addr %h want 1 %h", t, lat, a, want_a); end
      vectors++; if (sw !== (g == 2) || sr !== (g != 2)) begin miscompares++; $display("[TB] FAIL b2b%0d_kind: got r%b w%b grant %0d", t, sr, sw, g); end
      if (g == 2) begin
        vectors++; if (wl !== wd) begin miscompares++; $display("[TB] FAIL b2b%0d_beats: got %h want %h", t, wl, wd); end
      end
      vectors++; if (he !== 0 || er !== 0) begin miscompares++; $display("[TB] FAIL b2b%0d_hold: got hold_err %0d early %0d want 0 0", t, he, er); end
      vectors++; if (icache_pmem_resp !== (g == 0) || dcache_pmem_resp !== (g != 0)) begin miscompares++; $display("[TB] FAIL b2b%0d_resp: got i%b d%b grant %0d", t, icache_pmem_resp, dcache_pmem_resp, g); end
      vectors++; if (icache_pmem_rdata !== exp_i_rdata) begin miscompares++; $display("[TB] FAIL b2b%0d_i_rdata: got %h want %h", t, icache_pmem_rdata, exp_i_rdata); end
      vectors++; if (dcache_pmem_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL b2b%0d_d_rdata: got %h want %h", t, dcache_pmem_rdata, exp_d_rdata); end
      icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
      pmem_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      pmem_resp = 1'b0;
      vectors++; if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b%0d_idle: got i%b d%b r%b w%b want all 0", t, icache_pmem_resp, dcache_pmem_resp, pmem_read, pmem_write); end
    end
  endtask

  initial begin
    $display("[TB] pmem_arbiter bench start");
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_simultaneous();
    test_read_write_together();
    test_reset_mid_burst();
    test_slow_memory();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
